// File: rtl/timer_counter_if.sv
// rtl/timer_counter_if.sv - bridge-side register bus for one timer window
interface timer_counter_if;
  logic [29:0] addr;
  logic        WE;
  logic [31:0] Din;
  logic [31:0] Dout;
  logic        IRQ;

  modport master (output addr, output WE, output Din, input Dout, input IRQ);
  modport slave  (input addr, input WE, input Din, output Dout, output IRQ);
endinterface

// File: rtl/timer_counter.sv
// rtl/timer_counter.sv - down-counting bus timer with IRQ; optional prescaler via TC_PRESCALE_EN
module timer_counter #(
  parameter int CNT_W = 32
) (
  input  logic           clk,
  input  logic           reset,
  timer_counter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, LOAD, CNT, INT} state_e;

  state_e           state_q, state_d;
  logic [3:0]       ctrl_q, ctrl_d;
  logic [CNT_W-1:0] preset_q, preset_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             irq_flag_q, irq_flag_d;

  logic ctrl_wr, preset_wr, en, im, reload, step;
  logic unused_ok;

  assign ctrl_wr   = bus.WE && (bus.addr[1:0] == 2'd0);
  assign preset_wr = bus.WE && (bus.addr[1:0] == 2'd1);
  assign en        = ctrl_q[0];
  assign reload    = (ctrl_q[2:1] == 2'b01);
  assign im        = ctrl_q[3];
  assign unused_ok = ^{bus.addr[29:2], bus.Din};

`ifdef TC_PRESCALE_EN
  logic [15:0] prescale_q, prescale_d;
  logic [15:0] div_q, div_d;
  logic        prescale_wr;

  assign prescale_wr = bus.WE && (bus.addr[1:0] == 2'd3);
  assign step        = (div_q == prescale_q);
`else
  assign step = 1'b1;
`endif

  always_comb begin
    state_d    = state_q;
    ctrl_d     = ctrl_q;
    count_d    = count_q;
    irq_flag_d = irq_flag_q;
    preset_d   = preset_wr ? bus.Din[CNT_W-1:0] : preset_q;
`ifdef TC_PRESCALE_EN
    prescale_d = prescale_wr ? bus.Din[15:0] : prescale_q;
    div_d      = div_q;
`endif
    // A CTRL write clears the flag; an expiry later in this block overrides it.
    if (ctrl_wr) irq_flag_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (en) state_d = LOAD;
      end
      LOAD: begin
        count_d = preset_q;
        state_d = CNT;
`ifdef TC_PRESCALE_EN
        div_d = 16'd0;
`endif
      end
      CNT: begin
        if (!en) begin
          state_d = IDLE;
        end else begin
`ifdef TC_PRESCALE_EN
          div_d = step ? 16'd0 : div_q + 16'd1;
`endif
          if (step) begin
            if (count_q > CNT_W'(1)) begin
              count_d = count_q - CNT_W'(1);
            end else begin
              count_d    = '0;
              irq_flag_d = 1'b1;
              state_d    = INT;
            end
          end
        end
      end
      INT: begin
        if (reload) begin
          irq_flag_d = 1'b0;
          state_d    = en ? LOAD : IDLE;
        end else begin
          ctrl_d[0] = 1'b0;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Bus write lands last so it beats the one-shot EN clear.
    if (ctrl_wr) ctrl_d = bus.Din[3:0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      ctrl_q     <= '0;
      preset_q   <= '0;
      count_q    <= '0;
      irq_flag_q <= 1'b0;
`ifdef TC_PRESCALE_EN
      prescale_q <= '0;
      div_q      <= '0;
`endif
    end else begin
      state_q    <= state_d;
      ctrl_q     <= ctrl_d;
      preset_q   <= preset_d;
      count_q    <= count_d;
      irq_flag_q <= irq_flag_d;
`ifdef TC_PRESCALE_EN
      prescale_q <= prescale_d;
      div_q      <= div_d;
`endif
    end
  end

  always_comb begin
    bus.Dout = 32'd0;
    case (bus.addr[1:0])
      2'd0: bus.Dout = {28'd0, ctrl_q};
      2'd1: bus.Dout = 32'(preset_q);
      2'd2: bus.Dout = 32'(count_q);
`ifdef TC_PRESCALE_EN
      2'd3: bus.Dout = {16'd0, prescale_q};
`else
      2'd3: bus.Dout = 32'd0;
`endif
      default: bus.Dout = 32'd0;
    endcase
  end

  assign bus.IRQ = irq_flag_q & im;

endmodule

// File: tb/tb_timer_counter.sv
// tb/tb_timer_counter.sv - directed scoreboard bench for timer_counter
module tb_timer_counter;

  logic clk = 1'b0;
  logic reset;
  int   n_cmp = 0;
  int   n_err = 0;

  timer_counter_if bus ();

  timer_counter #(.CNT_W(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;

  exp_t sb[$];

  task automatic push(input string tag, input logic [31:0] val);
    exp_t e;
    e.tag = tag;
    e.val = val;
    sb.push_back(e);
  endtask

  task automatic chk(input logic [31:0] obs);
    exp_t e;
    n_cmp++;
    if (sb.size() == 0) begin
      n_err++;
      $error("FAIL sb_empty: observed %0h required an expected entry", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.val) else begin
        n_err++;
        $error("FAIL %s: observed %0h expected %0h", e.tag, obs, e.val);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    bus.addr = {28'd0, a};
    bus.Din  = d;
    bus.WE   = 1'b1;
    @(posedge clk);
    #1;
    bus.WE   = 1'b0;
  endtask

  task automatic rd(input logic [1:0] a, input string tag, input logic [31:0] expv);
    push(tag, expv);
    bus.addr = {28'd0, a};
    #1;
    chk(bus.Dout);
  endtask

  task automatic irq(input string tag, input logic expv);
    push(tag, {31'd0, expv});
    chk({31'd0, bus.IRQ});
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] ec;
    bus.addr = '0;
    bus.Din  = '0;
    bus.WE   = 1'b0;
    reset    = 1'b1;
    repeat (2) tick();
    reset = 1'b0;

    // reset state
    rd(0, "rst_ctrl", 0);
    rd(1, "rst_preset", 0);
    rd(2, "rst_count", 0);
    rd(3, "rst_off3", 0);
    irq("rst_irq", 1'b0);
    wr(2, 32'h55);
    rd(2, "count_ro", 0);
`ifndef TC_PRESCALE_EN
    wr(3, 32'hFFFF);
    rd(3, "reserved", 0);
`endif

    // one-shot, PRESET=5
    wr(1, 5);
    wr(0, 32'h9);
    for (int k = 1; k <= 6; k++) begin
      tick();
      ec = (k == 1) ? 32'd0 : 32'(7 - k);
      rd(2, $sformatf("os_count_e%0d", k), ec);
      irq($sformatf("os_irq_e%0d", k), 1'b0);
    end
    tick();
    rd(2, "os_count_e7", 0);
    irq("os_irq_e7", 1'b1);
    rd(0, "os_ctrl_e7", 32'h9);
    tick();
    rd(0, "os_ctrl_e8", 32'h8);
    irq("os_irq_e8", 1'b1);
    tick();
    irq("os_irq_hold", 1'b1);
    wr(0, 32'h8);
    irq("os_irq_clr", 1'b0);
    tick();
    irq("os_irq_clr2", 1'b0);

    // auto-reload, PRESET=3
    wr(1, 3);
    wr(0, 32'hB);
    for (int k = 1; k <= 15; k++) begin
      tick();
      if (k < 2) ec = 0;
      else begin
        case ((k - 2) % 5)
          0: ec = 3;
          1: ec = 2;
          2: ec = 1;
          default: ec = 0;
        endcase
      end
      rd(2, $sformatf("ar_count_e%0d", k), ec);
      irq($sformatf("ar_irq_e%0d", k), (k % 5 == 0));
    end
    wr(0, 0);
    tick();
    tick();
    rd(2, "ar_stop_count", 3);
    irq("ar_stop_irq", 1'b0);

    // mid-count PRESET write and disable
    wr(1, 4);
    wr(0, 32'h9);
    tick();
    tick();
    rd(2, "mc_count_e2", 4);
    wr(1, 10);
    rd(2, "mc_count_e3", 3);
    wr(0, 32'h8);
    rd(2, "mc_count_e4", 2);
    tick();
    rd(2, "mc_hold_e5", 2);
    tick();
    rd(2, "mc_hold_e6", 2);
    rd(1, "mc_preset", 10);
    wr(0, 32'h9);
    tick();
    rd(2, "mc_load_f1", 2);
    tick();
    rd(2, "mc_reload_f2", 10);
    irq("mc_irq", 1'b0);
    wr(0, 0);
    tick();
    tick();

    // IM=0 expiry
    wr(1, 1);
    wr(0, 32'h1);
    tick();
    tick();
    rd(2, "nm_count_e2", 1);
    tick();
    rd(2, "nm_count_e3", 0);
    irq("nm_irq_e3", 1'b0);
    tick();
    rd(0, "nm_ctrl_e4", 0);
    wr(0, 32'h8);
    irq("nm_irq_after_wr", 1'b0);
    tick();
    irq("nm_irq_later", 1'b0);

    // PRESET=0 boundary
    wr(1, 0);
    wr(0, 32'h9);
    tick();
    tick();
    irq("z_irq_e2", 1'b0);
    tick();
    irq("z_irq_e3", 1'b1);
    tick();
    irq("z_irq_e4", 1'b1);
    wr(0, 32'h8);
    irq("z_irq_clr", 1'b0);

    // expiry and CTRL write on the same edge; CTRL write vs one-shot EN clear
    wr(0, 32'h9);
    tick();
    tick();
    wr(0, 32'h8);
    irq("sw_set_wins", 1'b1);
    wr(0, 32'h9);
    rd(0, "sw_ctrl_wins", 32'h9);
    irq("sw_irq_cleared", 1'b0);
    wr(0, 0);
    repeat (3) tick();
    irq("sw_irq_idle", 1'b0);

`ifdef TC_PRESCALE_EN
    // prescaler: PRESCALE=2, PRESET=2
    wr(3, 2);
    rd(3, "ps_reg", 2);
    wr(1, 2);
    wr(0, 32'h9);
    tick();
    for (int k = 2; k <= 8; k++) begin
      tick();
      ec = (k <= 4) ? 32'd2 : (k <= 7) ? 32'd1 : 32'd0;
      rd(2, $sformatf("ps_count_e%0d", k), ec);
      irq($sformatf("ps_irq_e%0d", k), (k == 8));
    end
    tick();
    wr(0, 32'h8);
`endif

    // reset mid-count
    wr(1, 7);
    wr(0, 32'h9);
    repeat (3) tick();
    rd(2, "mr_count_pre", 6);
    reset = 1'b1;
    tick();
    rd(0, "mr_ctrl", 0);
    rd(1, "mr_preset", 0);
    rd(2, "mr_count", 0);
    rd(3, "mr_off3", 0);
    irq("mr_irq", 1'b0);
    reset = 1'b0;
    tick();
    rd(2, "mr_idle_count", 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/timer_counter.md
Name: timer_counter

Overview:
Memory-mapped down-counting timer that serves as a responder on the CPU data bridge. Each timer instance occupies one 16-byte window behind the bridge's TC1/TC2 decode. The bridge supplies a word address, a full-word write strobe and the write data, and returns this block's read data to the CPU. The block counts down from a preset value and raises an interrupt request to the CPU when the count expires.

Parameters:
- CNT_W, default 32: width of the PRESET and COUNT registers. Narrower values are zero-extended on read.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- reset  input  1  synchronous, active-high reset.
- addr  input  30  word address (byte address bits [31:2]). Only addr[1:0] (byte-address bits [3:2]) are decoded.
- WE  input  1  full-word write strobe from the bridge. Writes only; there is no read strobe.
- Din  input  32  write data.
- Dout  output  32  read data; combinational from addr and the current register state.
- IRQ  output  1  interrupt request, level, active-high.

Behaviour:
Register map (word offset = addr[1:0]):
- 0 CTRL: bit0 EN (enable), bits[2:1] MODE, bit3 IM (interrupt mask); other bits read 0.
  - MODE 00: one-shot. MODE 01: auto-reload. MODE 1x: treated as 00.
- 1 PRESET: read/write.
- 2 COUNT: read-only; writes ignored.
- 3 reserved: reads 0, writes ignored.

Reset: CTRL=0, PRESET=0, COUNT=0, state=IDLE, irq_flag=0. Dout therefore reads 0 at every offset; IRQ=0.

IRQ = irq_flag & CTRL.IM, purely combinational.

FSM states are IDLE, LOAD, CNT and INT. One transition per clock:
- IDLE: if EN, go to LOAD; otherwise stay.
- LOAD: COUNT <= PRESET; go to CNT.
- CNT:
  - if !EN, go to IDLE; COUNT holds.
  - else if COUNT > 1, COUNT <= COUNT - 1.
  - else COUNT <= 0, irq_flag <= 1, go to INT.
- INT:
  - MODE 00: clear EN, go to IDLE. irq_flag stays 1 until any CTRL write.
  - MODE 01: irq_flag <= 0 (a one-cycle pulse), go to LOAD.

Latency, for PRESET=N≥1 with EN written at edge 0:
- State is LOAD after edge 1.
- COUNT=N after edge 2.
- COUNT=0 and IRQ high after edge N+2.
- PRESET=0: IRQ high after edge 3.

Simultaneous events:
- A bus write to CTRL has priority over the FSM clearing EN in the same cycle.
- Any CTRL write clears irq_flag, unless the FSM sets irq_flag in that same cycle, in which case the set wins.
- A PRESET write while counting does not affect COUNT until the next LOAD.
- Clearing EN during LOAD or INT: LOAD completes, INT completes, then the FSM goes to IDLE.
- Reset asserted mid-count returns every register and the state to reset values on that edge.

Width: COUNT decrements modulo 2^CNT_W, but it never underflows because the >1 check prevents it.

Optional Feature:
Macro: TC_PRESCALE_EN
- Defined:
  - Offset 3 becomes PRESCALE, a 16-bit read/write register, reset 0.
  - An internal 16-bit divider counts clocks in state CNT only and is cleared on LOAD.
  - COUNT is decremented (or expires) only on cycles where the divider equals PRESCALE; the divider then wraps to 0.
  - PRESCALE=0 is identical to behaviour without the macro.
- Not defined: offset 3 is reserved exactly as above, and COUNT steps every CNT cycle.

Test Plan:
- Reset, then read all offsets -> Dout=0 at each; IRQ=0.
- Write PRESET=5, then CTRL=0x9 (EN, one-shot, IM) at edge 0 -> COUNT reads 5,4,3,2,1 after edges 2..6; IRQ rises after edge 7; CTRL.EN reads 0; IRQ stays high until a CTRL write of 0x8, after which IRQ=0 on the next edge.
- PRESET=3, CTRL=0xB (auto-reload, IM) -> IRQ one-cycle pulses every 5 cycles (LOAD, CNT×3, INT); COUNT sequence 3,2,1,0,·,3,...
- Mid-count write PRESET=10, then CTRL.EN=0 at COUNT=2 -> FSM to IDLE, COUNT holds 2; re-enable -> COUNT reloads 10.
- IM=0 with expiry in one-shot mode -> IRQ stays 0 while irq_flag is internally set; then writing CTRL=0x8 clears irq_flag, so IRQ stays 0.
- (TC_PRESCALE_EN) PRESCALE=2, PRESET=2 -> COUNT is held for 3 cycles per step; IRQ rises 6 CNT cycles after LOAD. Assert reset mid-count -> all registers read 0 on the next edge.
